// File: rtl/seg7_scan_decoder.sv
// Multiplexed 7-segment scan decoder: captures each digit once its select and segment pattern hold steady.
// Optional macro SEG7_SCAN_DP_CAPTURE_EN adds decimal-point capture into dp_out.
`timescale 1ns/1ps
module seg7_scan_decoder #(
  parameter int unsigned STABLE_CYCLES = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [3:0]  line,
  input  logic [6:0]  seg,
  input  logic        dp,
  output logic [15:0] hex,
  output logic [3:0]  valid,
  output logic [3:0]  code_err,
  output logic [3:0]  dp_out,
  output logic        frame_done
);

`ifdef SEG7_SCAN_DP_CAPTURE_EN
  localparam int KW = 12;
`else
  localparam int KW = 11;
`endif

  typedef enum logic [1:0] {IDLE, SETTLE, HOLD} state_t;

  logic [KW-1:0] raw;
  logic [KW-1:0] s1_reg;
  logic [KW-1:0] s2_reg;
  logic [KW-1:0] prev_reg;
  logic [3:0]    sync_line;
  logic [6:0]    sync_seg;
  logic [3:0]    sel_low;
  logic          one_hot;
  logic          changed;

  state_t        state_reg;
  state_t        state_next;
  logic [7:0]    cnt_reg;
  logic [7:0]    cnt_next;
  logic [7:0]    cnt_inc;
  logic          capture;

  logic          dec_legal;
  logic [3:0]    dec_val;
  logic [3:0]    hit;
  logic [3:0]    seen_reg;
  logic [3:0]    seen_next;
  logic          frame_complete;

  logic [15:0]   hex_reg;
  logic [3:0]    valid_reg;
  logic [3:0]    code_err_reg;
  logic          frame_done_reg;

`ifdef SEG7_SCAN_DP_CAPTURE_EN
  logic          sync_dp;
  logic [3:0]    dp_reg;
  assign raw     = {line, seg, dp};
  assign sync_dp = s2_reg[0];
  assign dp_out  = dp_reg;
`else
  logic          unused_dp;
  assign raw       = {line, seg};
  assign unused_dp = dp;
  assign dp_out    = 4'b0000;
`endif

  assign sync_line = s2_reg[KW-1 -: 4];
  assign sync_seg  = s2_reg[KW-5 -: 7];

  // Two-flop synchronizer plus a copy of the previous synced word for change detection.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_reg   <= '0;
      s2_reg   <= '0;
      prev_reg <= '0;
    end else begin
      s1_reg   <= raw;
      s2_reg   <= s1_reg;
      prev_reg <= s2_reg;
    end
  end

  assign sel_low = ~sync_line;
  assign one_hot = (sel_low != 4'b0000) && ((sel_low & (sel_low - 4'd1)) == 4'b0000);
  assign changed = (s2_reg != prev_reg);
  assign cnt_inc = cnt_reg + 8'd1;

  function automatic logic [4:0] decode(input logic [6:0] code);
    logic [4:0] r;
    case (code)
      7'h7E:   r = {1'b1, 4'h0};
      7'h30:   r = {1'b1, 4'h1};
      7'h6D:   r = {1'b1, 4'h2};
      7'h79:   r = {1'b1, 4'h3};
      7'h33:   r = {1'b1, 4'h4};
      7'h5B:   r = {1'b1, 4'h5};
      7'h5F:   r = {1'b1, 4'h6};
      7'h70:   r = {1'b1, 4'h7};
      7'h7F:   r = {1'b1, 4'h8};
      7'h7B:   r = {1'b1, 4'h9};
      7'h77:   r = {1'b1, 4'hA};
      7'h1F:   r = {1'b1, 4'hB};
      7'h4E:   r = {1'b1, 4'hC};
      7'h3D:   r = {1'b1, 4'hD};
      7'h4F:   r = {1'b1, 4'hE};
      7'h47:   r = {1'b1, 4'hF};
      default: r = {1'b0, 4'h0};
    endcase
    return r;
  endfunction

  assign {dec_legal, dec_val} = decode(sync_seg);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= IDLE;
      cnt_reg   <= 8'd0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
    end
  end

  // Any change restarts the stability window; the capture fires on the edge the count reaches STABLE_CYCLES.
  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    capture    = 1'b0;
    if (changed) begin
      if (one_hot) begin
        state_next = SETTLE;
        cnt_next   = 8'd1;
      end else begin
        state_next = IDLE;
        cnt_next   = 8'd0;
      end
    end else begin
      case (state_reg)
        IDLE: begin
          cnt_next = 8'd0;
        end
        SETTLE: begin
          cnt_next = cnt_inc;
          if (cnt_inc == 8'(STABLE_CYCLES)) begin
            capture    = 1'b1;
            state_next = HOLD;
          end
        end
        HOLD: begin
          state_next = HOLD;
        end
        default: begin
          state_next = IDLE;
          cnt_next   = 8'd0;
        end
      endcase
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_hit
      assign hit[gi] = capture & sel_low[gi];
    end
  endgenerate

  assign seen_next      = seen_reg | hit;
  assign frame_complete = capture && (seen_next == 4'b1111);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      seen_reg       <= 4'b0000;
      frame_done_reg <= 1'b0;
      hex_reg        <= 16'h0000;
      valid_reg      <= 4'b0000;
      code_err_reg   <= 4'b0000;
    end else begin
      frame_done_reg <= frame_complete;
      if (capture) begin
        seen_reg <= frame_complete ? 4'b0000 : seen_next;
      end
      for (int i = 0; i < 4; i++) begin
        if (hit[i]) begin
          if (dec_legal) begin
            hex_reg[4*i +: 4] <= dec_val;
            valid_reg[i]      <= 1'b1;
            code_err_reg[i]   <= 1'b0;
          end else begin
            valid_reg[i]      <= 1'b0;
            code_err_reg[i]   <= 1'b1;
          end
        end
      end
    end
  end

`ifdef SEG7_SCAN_DP_CAPTURE_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dp_reg <= 4'b0000;
    end else begin
      for (int i = 0; i < 4; i++) begin
        if (hit[i]) begin
          dp_reg[i] <= sync_dp;
        end
      end
    end
  end
`endif

  assign hex        = hex_reg;
  assign valid      = valid_reg;
  assign code_err   = code_err_reg;
  assign frame_done = frame_done_reg;

endmodule
